doubling_recursion: RTL and testbench

//  16-bit add/subtract datapath whose carries come from a recursive-doubling (Kogge-Stone) prefix tree.

---
 rtl/doubling_recursion_pkg.sv | 31 +++
 rtl/doubling_recursion_if.sv | 20 ++
 rtl/doubling_recursion_kpg_cell.sv | 17 +
 rtl/doubling_recursion.sv | 140 ++++++++++++++
 tb/tb_doubling_recursion.sv | 132 +++++++++++++
 5 files changed

// File: rtl/doubling_recursion_pkg.sv
// ============================================================================
// doubling_pkg : KPG carry classes and combine operator for the prefix adder
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package doubling_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEPTH         = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    KILL = 2'b00,
    PROP = 2'b01,
    GEN  = 2'b11
  } kpg_t;

  function automatic kpg_t kpg_classify(input logic x, input logic y);
    if (x & y)      return GEN;
    else if (x ^ y) return PROP;
    else            return KILL;
  endfunction

  // A decided upper span wins; a propagating one defers to the span below it.
  function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
    return (hi == PROP) ? lo : hi;
  endfunction

endpackage

`default_nettype wire

// File: rtl/doubling_recursion_if.sv
// ============================================================================
// doubling_recursion_if : operand/result bundle of the prefix add/sub datapath
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface doubling_recursion_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sgn;
  logic [WIDTH:0]   ans;

  modport master (output a, output b, output cin, output sgn, input  ans);
  modport slave  (input  a, input  b, input  cin, input  sgn, output ans);
endinterface

`default_nettype wire

// File: rtl/doubling_recursion_kpg_cell.sv
// ============================================================================
// kpg_cell : one node of the recursive-doubling prefix tree
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module kpg_cell
  import doubling_pkg::*;
(
  input  kpg_t hi,
  input  kpg_t lo,
  output kpg_t res
);
  assign res = kpg_combine(hi, lo);
endmodule

`default_nettype wire

// File: rtl/doubling_recursion.sv
// ============================================================================
// doubling_recursion : registered add/subtract with Kogge-Stone KPG carries
// Optional macro INPUT_REG_EN registers the operands first (latency 2).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module doubling_recursion
  import doubling_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)(
  input  logic                 clk,
  input  logic                 rst_n,
  doubling_recursion_if.slave  bus
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_sgn;

`ifdef INPUT_REG_EN
  logic [WIDTH-1:0] a_d, a_q, b_d, b_q;
  logic             cin_d, cin_q, sgn_d, sgn_q;

  always_comb begin
    a_d   = bus.a;
    b_d   = bus.b;
    cin_d = bus.cin;
    sgn_d = bus.sgn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      sgn_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cin_q <= cin_d;
      sgn_q <= sgn_d;
    end
  end

  assign op_a   = a_q;
  assign op_b   = b_q;
  assign op_cin = cin_q;
  assign op_sgn = sgn_q;
`else
  assign op_a   = bus.a;
  assign op_b   = bus.b;
  assign op_cin = bus.cin;
  assign op_sgn = bus.sgn;
`endif

  // Subtraction is a + ~b + ~cin; the carry-out is then the inverted borrow.
  logic [WIDTH-1:0] bb;
  logic             c0;

  always_comb begin
    bb = op_sgn ? op_b : ~op_b;
    c0 = op_sgn ? op_cin : ~op_cin;
  end

  // Node 0 is the virtual carry-in bit; node i+1 holds operand bit i.
  kpg_t x0 [WIDTH+1];

  always_comb begin
    x0[0] = c0 ? GEN : KILL;
    for (int i = 0; i < WIDTH; i++) begin
      x0[i+1] = kpg_classify(op_a[i], bb[i]);
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    kpg_t cur [WIDTH+1];
    kpg_t nxt [WIDTH+1];

    if (k == 0) begin : g_first
      assign cur = x0;
    end else begin : g_chain
      assign cur = g_level[k-1].nxt;
    end

    for (genvar j = 0; j <= WIDTH; j++) begin : g_node
      if (j >= (1 << k)) begin : g_cell
        kpg_cell u_cell (
          .hi  (cur[j]),
          .lo  (cur[j - (1 << k)]),
          .res (nxt[j])
        );
      end else begin : g_pass
        assign nxt[j] = cur[j];
      end
    end
  end

  kpg_t tree [WIDTH+1];
  kpg_t cout_class;

  assign tree = g_level[LEVELS-1].nxt;

  // The top node spans bits 1..WIDTH only, so it can still be PROP; folding in
  // the virtual carry-in node resolves an all-propagate chain into the carry-out.
  kpg_cell u_cout (
    .hi  (tree[WIDTH]),
    .lo  (tree[0]),
    .res (cout_class)
  );

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   ans_d;
  logic [WIDTH:0]   ans_q;

  always_comb begin
    carry[0] = c0;
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = (tree[i] == GEN);
    end
    carry[WIDTH] = (cout_class == GEN);
    sum          = op_a ^ bb ^ carry[WIDTH-1:0];
    ans_d        = {carry[WIDTH], sum};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ans_q <= '0;
    else        ans_q <= ans_d;
  end

  assign bus.ans = ans_q;

endmodule

`default_nettype wire

// File: tb/tb_doubling_recursion.sv
// ============================================================================
// tb_doubling_recursion : directed and streamed checks of doubling_recursion
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_doubling_recursion;

`ifdef INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  doubling_recursion_if #(.WIDTH(16)) bus ();

  doubling_recursion #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%05h expected=%05h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sgn);
    if (sgn) return {1'b0, a} + {1'b0, b} + {16'd0, cin};
    else     return {1'b0, a} + {1'b0, ~b} + {16'd0, ~cin};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sgn);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    bus.sgn = sgn;
  endtask

  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sgn, input logic [16:0] exp);
    @(negedge clk);
    drive(a, b, cin, sgn);
    repeat (LAT) @(negedge clk);
    chk(tag, bus.ans, exp);
  endtask

  logic [16:0] exp_q [$];

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    drive(16'h1234, 16'h4321, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1 chk("reset", bus.ans, 17'h00000);
    @(negedge clk);
    rst_n = 1'b1;

    // Add, cin=0
    run_vec("add_0_0",   16'd0,     16'd0,     1'b0, 1'b1, 17'd0);
    run_vec("add_1_0",   16'd1,     16'd0,     1'b0, 1'b1, 17'd1);
    run_vec("add_3_3",   16'd3,     16'd3,     1'b0, 1'b1, 17'd6);
    run_vec("add_11_7",  16'd11,    16'd7,     1'b0, 1'b1, 17'd18);
    run_vec("add_30f_f", 16'h030F,  16'h000F,  1'b0, 1'b1, 17'd798);
    run_vec("add_56_5d", 16'h0056,  16'h005D,  1'b0, 1'b1, 17'd179);
    // Full-length propagate chains
    run_vec("add_ffff_0_c1",    16'hFFFF, 16'h0000, 1'b1, 1'b1, 17'h10000);
    run_vec("add_ffff_ffff_c1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 17'h1FFFF);
    // Subtract
    run_vec("sub_5560_8101",   16'd5560,  16'd8101,  1'b0, 1'b0, 17'd62995);
    run_vec("sub_61560_60101", 16'd61560, 16'd60101, 1'b0, 1'b0, 17'd66995);
    run_vec("sub_0_1",         16'd0,     16'd1,     1'b0, 1'b0, 17'd65535);
    run_vec("sub_7_7",         16'd7,     16'd7,     1'b0, 1'b0, 17'd65536);
    run_vec("sub_10_3_b1",     16'd10,    16'd3,     1'b1, 1'b0, 17'd65542);

    // Back-to-back stream, one new operation per cycle
    for (int n = 0; n < 200 + LAT; n++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      @(negedge clk);
      if (exp_q.size() == LAT) chk("stream", bus.ans, exp_q.pop_front());
      if (n < 200) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        if (n % 50 == 0) begin
          ra = 16'hFFFF;
          rb = rs ? 16'h0000 : 16'hFFFF;
        end
        drive(ra, rb, rc, rs);
        exp_q.push_back(model(ra, rb, rc, rs));
      end
    end

    // Asynchronous reset mid-stream
    @(negedge clk);
    drive(16'h8000, 16'h8000, 1'b0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", bus.ans, 17'h00000);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b1, 17'h00100);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
